load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Bus master between the core's memory stage and the byte-lane data RAM.
//  - Accepts one load/store per valid/ready handshake and checks size, alignment and address range.
//  - Drives the RAM req/gnt bus, holding every bus field stable until grant, then returns read data or an error code.
//  - One transaction outstanding at a time.
// PARAMETERS
//  RAM_BASE   32'h0000_0000  byte base address of the RAM window
//  RAM_BYTES  1024           window size in bytes (4 lanes x 256 entries)
//  TIMEOUT    15             max REQ cycles without grant (LSU_TIMEOUT_EN only)
// PORTS
//  clk_i      in   1   system clock
//  rst_i      in   1   synchronous active-high reset
//  valid_i    in   1   core request valid
//  ready_o    out  1   LSU can accept a request (high only in IDLE)
//  we_i       in   1   1 = store, 0 = load
//  hb_i       in   2   size: 00 byte, 01 half, 10 word, 11 illegal
//  uload_i    in   1   zero-extend load
//  addr_i     in   32  byte address
//  wdata_i    in   32  store data, LSB-aligned (RAM selects the lane)
//  done_o     out  1   one-cycle completion pulse
//  rdata_o    out  32  load result; valid with done_o, held until next done_o
//  err_o      out  1   completion carries an error (valid with done_o)
//  err_code_o out  2   00 none, 01 misaligned, 10 range/illegal size, 11 timeout
//  ce_o       out  1   RAM chip enable (high in REQ)
//  req_o      out  1   RAM request
//  gnt_i      in   1   RAM grant (registered by RAM, one cycle after req & ce)
//  addr_o, wdata_o  out 32 / we_o, uload_o  out 1 / hb_o  out 2   registered bus fields
//  rdata_i    in   32  RAM read data, combinational while req & ce held
// BEHAVIOUR
//  Reset: state=IDLE; req_o=ce_o=done_o=err_o=0; err_code_o=00; rdata_o=0; bus fields=0; ready_o=1.
//  FSM IDLE -> REQ -> RESP -> IDLE; a faulted request goes IDLE -> RESP directly.
//  IDLE: valid_i & ready_o latches all request fields at the clock edge.
//    - Fault check on the latched request: hb=11 -> 10; addr outside [RAM_BASE, RAM_BASE+RAM_BYTES) -> 10;
//      hb=01 & addr[0] -> 01; hb=10 & addr[1:0]!=0 -> 01. Range/illegal-size takes priority over misalignment.
//    - Fault -> RESP with err; no bus activity (req_o stays 0, so no RAM write occurs).
//    - No fault -> REQ.
//  REQ: req_o=ce_o=1; bus fields frozen; addr_o = addr_i - RAM_BASE.
//    - gnt_i is sampled only in REQ. On gnt_i=1, rdata_i is captured (loads only) and the FSM goes to RESP.
//  RESP: done_o=1 for exactly one cycle; req_o=0; ready_o=0; then IDLE.
//    - A stale gnt_i in RESP/IDLE is ignored.
//    - Because ready_o=0 in RESP, the RAM's registered gnt is low before the next REQ.
//  Latency with no RAM stall: accept edge N; REQ cycles N+1 and N+2 (gnt seen in N+2); done_o in cycle N+3.
//    Faulted request: done_o in cycle N+1. Throughput: one op per 4 cycles.
//  Stores: rdata_o is left unchanged.
//  Loads: rdata_o = rdata_i unmodified; the RAM performs sign/zero extension.
//  Error completion: rdata_o is left unchanged.
//  rst_i mid-REQ: req_o drops on the next edge. A store whose write edge has already passed stays written; no done_o is issued.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//    - A 4-bit counter clears on entry to REQ and increments each REQ cycle without gnt_i.
//    - When the count reaches TIMEOUT: RESP with err_code 11, req_o dropped.
//  Macro undefined: no counter; REQ waits indefinitely for gnt_i and err_code 11 is never produced.
// STRUCTURE
//  lsu_pkg (shared include): state encodings, HB_BYTE/HB_HALF/HB_WORD/HB_ILL, ERR_* codes.
//  Sub-module lsu_align_check: combinational (hb, addr, RAM_BASE, RAM_BYTES) -> {fault, code}.
//  Top level: FSM, request/bus registers, response registers, optional timeout counter.
// TESTING
//  1 Store word 32'hDEADBEEF @0x10, then load word @0x10 -> done_o on cycle N+3 of each op; rdata_o=DEADBEEF, err_o=0.
//  2 Store byte 8'h80 @0x21; load byte signed @0x21 -> rdata_o=FFFFFF80; load unsigned -> rdata_o=00000080.
//  3 Load half @0x13 -> done_o at N+1, err_code_o=01, req_o never high, rdata_o unchanged.
//  4 Store word @RAM_BASE+RAM_BYTES, and a request with hb=11 -> err_code_o=10, no RAM write (memory readback unchanged).
//  5 LSU_TIMEOUT_EN, gnt_i forced 0 -> done_o exactly TIMEOUT REQ cycles after entry, err_code_o=11; next op succeeds.
//  6 Assert rst_i during REQ of a load -> next cycle req_o=0, ready_o=1, no done_o; a following load returns correct data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding,
// access-size encodings and completion error codes.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Access size (hb) encodings
   localparam logic [1:0] HB_BYTE = 2'b00;
   localparam logic [1:0] HB_HALF = 2'b01;
   localparam logic [1:0] HB_WORD = 2'b10;
   localparam logic [1:0] HB_ILL  = 2'b11;

   // Completion error codes
   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_align_check.sv
// Request fault classifier (purely combinational).
// Ports:
//   hb      in   2   access size
//   addr    in   32  byte address
//   fault_c out  1   request must not reach the RAM
//   code_c  out  2   ERR_RANGE for bad size/out of window, else ERR_MISALIGN
module lsu_align_check
   import lsu_pkg::*;
#(
   parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
   parameter int unsigned RAM_BYTES = 1024
)(
   input  logic [1:0]  hb,
   input  logic [31:0] addr,
   output logic        fault_c,
   output logic [1:0]  code_c
);

   logic [32:0] diff;
   logic        in_range;

   // Range/illegal size outranks misalignment
   always_comb begin
      diff     = {1'b0, addr} - {1'b0, RAM_BASE};
      in_range = !diff[32] && (diff[31:0] < 32'(RAM_BYTES));
      fault_c  = 1'b0;
      code_c   = ERR_NONE;
      if (hb == HB_ILL || !in_range) begin
         fault_c = 1'b1;
         code_c  = ERR_RANGE;
      end else if ((hb == HB_HALF && addr[0]) ||
                   (hb == HB_WORD && addr[1:0] != 2'b00)) begin
         fault_c = 1'b1;
         code_c  = ERR_MISALIGN;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store bus master between the memory stage and a byte-lane data RAM.
// One transaction outstanding; bus fields held stable until grant.
// Optional feature: define LSU_TIMEOUT_EN to abort a REQ that sees no grant
// for TIMEOUT cycles (err_code 11).
// Ports:
//   clk_i, rst_i (sync, active high)
//   valid_i/ready_o, we_i, hb_i, uload_i, addr_i, wdata_i : core request
//   done_o, rdata_o, err_o, err_code_o                   : completion
//   ce_o, req_o, gnt_i, addr_o, wdata_o, we_o, uload_o,
//   hb_o, rdata_i                                         : RAM bus
module load_store_unit
   import lsu_pkg::*;
#(
   parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
   parameter int unsigned RAM_BYTES = 1024,
   parameter int unsigned TIMEOUT   = 15
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic        we_i,
   input  logic [1:0]  hb_i,
   input  logic        uload_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic        ce_o,
   output logic        req_o,
   input  logic        gnt_i,
   output logic [31:0] addr_o,
   output logic [31:0] wdata_o,
   output logic        we_o,
   output logic        uload_o,
   output logic [1:0]  hb_o,
   input  logic [31:0] rdata_i
);

   state_t     state;
   logic       fault_c;
   logic [1:0] code_c;

   // Classify the incoming request; the result is registered at accept
   lsu_align_check #(
      .RAM_BASE  (RAM_BASE),
      .RAM_BYTES (RAM_BYTES)
   ) u_align_check (
      .hb      (hb_i),
      .addr    (addr_i),
      .fault_c (fault_c),
      .code_c  (code_c)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned     CNT_W   = 4;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0] to_cnt;
`endif

   // FSM with request, bus and response registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         ready_o    <= 1'b1;
         done_o     <= 1'b0;
         rdata_o    <= 32'h0;
         err_o      <= 1'b0;
         err_code_o <= ERR_NONE;
         ce_o       <= 1'b0;
         req_o      <= 1'b0;
         addr_o     <= 32'h0;
         wdata_o    <= 32'h0;
         we_o       <= 1'b0;
         uload_o    <= 1'b0;
         hb_o       <= 2'b00;
`ifdef LSU_TIMEOUT_EN
         to_cnt     <= '0;
`endif
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid_i && ready_o) begin
                  ready_o <= 1'b0;
                  we_o    <= we_i;
                  hb_o    <= hb_i;
                  uload_o <= uload_i;
                  addr_o  <= addr_i - RAM_BASE;
                  wdata_o <= wdata_i;
                  if (fault_c) begin
                     // Faulted request never touches the bus
                     state      <= ST_RESP;
                     done_o     <= 1'b1;
                     err_o      <= 1'b1;
                     err_code_o <= code_c;
                  end else begin
                     state <= ST_REQ;
                     req_o <= 1'b1;
                     ce_o  <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                     to_cnt <= '0;
`endif
                  end
               end
            end
            ST_REQ: begin
               if (gnt_i) begin
                  req_o      <= 1'b0;
                  ce_o       <= 1'b0;
                  state      <= ST_RESP;
                  done_o     <= 1'b1;
                  err_o      <= 1'b0;
                  err_code_o <= ERR_NONE;
                  if (!we_o) begin
                     rdata_o <= rdata_i;
                  end
               end
`ifdef LSU_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  req_o      <= 1'b0;
                  ce_o       <= 1'b0;
                  state      <= ST_RESP;
                  done_o     <= 1'b1;
                  err_o      <= 1'b1;
                  err_code_o <= ERR_TIMEOUT;
               end else begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
`endif
            end
            ST_RESP: begin
               // Holding ready low here lets a stale RAM grant drain
               state   <= ST_IDLE;
               ready_o <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               ready_o <= 1'b1;
               req_o   <= 1'b0;
               ce_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule
